// File: rtl/fir4_out_stage.sv
// ----------------------------------------------------------------------------
// fir4_out_stage
// Output stage for a free-running 4-tap FIR. The signed FIR sum is rounded
// (round-half-up, arithmetic shift right by SHIFT), saturated to OW bits and
// buffered in a DEPTH-entry FIFO with a valid/ready consumer interface.
// The FIR side cannot be stalled, so samples arriving at a full FIFO are
// dropped and flagged with a sticky overflow bit.
//
// Optional feature macro: FIR4_OUT_SAT_CNT_EN
//   When defined, adds sat_cnt[15:0], a saturating count of clipped samples.
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   s_in      in   signed FIR sum, w+2 bits
//   s_valid   in   s_in carries a new sample this cycle
//   m_data    out  signed head-of-FIFO sample (0 when empty)
//   m_valid   out  FIFO non-empty
//   m_ready   in   consumer accepts m_data
//   level     out  FIFO occupancy
//   full      out  level == DEPTH
//   overflow  out  sticky: a sample was dropped
//   sat_cnt   out  clipped-sample count (FIR4_OUT_SAT_CNT_EN only)
// ----------------------------------------------------------------------------
module fir4_out_stage #(
  parameter int w     = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [w+1:0]         s_in,
  input  logic                        s_valid,
  output logic signed [OW-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        full,
  output logic                        overflow
`ifdef FIR4_OUT_SAT_CNT_EN
  ,
  output logic [15:0]                 sat_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [w+2:0]        ONE     = {{(w+2){1'b0}}, 1'b1};
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [w+2:0] RND     = (ONE << SHIFT) >> 1;
  localparam logic signed [w+2:0] SAT_MAX = (ONE << (OW - 1)) - ONE;
  localparam logic signed [w+2:0] SAT_MIN = ~SAT_MAX;

  logic signed [w+2:0]  sum_s;
  logic signed [w+2:0]  p1_d, p1_q;
  logic                 p1_v_q;
  logic signed [OW-1:0] p2_d, p2_q;
  logic                 p2_v_q;
  logic                 clip_s;

  logic [PW-1:0]        wr_q, rd_q, wr_d, rd_d;
  logic signed [OW-1:0] mem_q [DEPTH];
  logic                 ovf_q, ovf_d;
  logic                 empty_s, full_s, pop_s, push_ok_s;

  // Rounding: sign-extend to w+3 bits first so adding RND can never wrap.
  always_comb begin
    sum_s = $signed({s_in[w+1], s_in}) + RND;
    p1_d  = sum_s >>> SHIFT;
  end

  // Saturation of the rounded value to the OW-bit output range.
  always_comb begin
    clip_s = 1'b0;
    p2_d   = p1_q[OW-1:0];
    if (p1_q > SAT_MAX) begin
      clip_s = 1'b1;
      p2_d   = SAT_MAX[OW-1:0];
    end else if (p1_q < SAT_MIN) begin
      clip_s = 1'b1;
      p2_d   = SAT_MIN[OW-1:0];
    end else begin
      p2_d   = p1_q[OW-1:0];
    end
  end

  // FIFO control: a pop frees a slot in the same edge, so push+pop at full is legal.
  always_comb begin
    empty_s   = (wr_q == rd_q);
    full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_s     = !empty_s && m_ready;
    push_ok_s = p2_v_q && (!full_s || pop_s);
    wr_d      = push_ok_s ? wr_q + {{(PW-1){1'b0}}, 1'b1} : wr_q;
    rd_d      = pop_s ? rd_q + {{(PW-1){1'b0}}, 1'b1} : rd_q;
    ovf_d     = ovf_q || (p2_v_q && full_s && !pop_s);
  end

  // Pipeline valids, pipeline data, FIFO pointers and overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q   <= '0;
      p1_v_q <= 1'b0;
      p2_q   <= '0;
      p2_v_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (s_valid) begin
        p1_q <= p1_d;
      end
      p1_v_q <= s_valid;
      if (p1_v_q) begin
        p2_q <= p2_d;
      end
      p2_v_q <= p1_v_q;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage; contents are only observed through m_data when non-empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_q[AW-1:0]] <= p2_q;
    end
  end

  // Output decode from registered pointer state; m_data is forced to 0 when empty.
  always_comb begin
    m_valid  = !empty_s;
    level    = wr_q - rd_q;
    full     = full_s;
    overflow = ovf_q;
    if (m_valid) begin
      m_data = mem_q[rd_q[AW-1:0]];
    end else begin
      m_data = '0;
    end
  end

`ifdef FIR4_OUT_SAT_CNT_EN
  logic [15:0] sat_q;

  // Clip counter: counts every clipped sample entering P2, sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 16'h0000;
    end else if (p1_v_q && clip_s && (sat_q != 16'hFFFF)) begin
      sat_q <= sat_q + 16'h0001;
    end else begin
      sat_q <= sat_q;
    end
  end

  assign sat_cnt = sat_q;
`endif

endmodule

// File: tb/tb_fir4_out_stage.sv
// ----------------------------------------------------------------------------
// tb_fir4_out_stage
// Directed bench: a default instance (OW=16) and an OW=12 instance share all
// stimulus. A table of single-sample vectors covers rounding and saturation;
// hand-written sequences cover async reset, overflow, full-with-pop and a
// random back-to-back stream checked against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_fir4_out_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic signed [17:0] s_in;
  logic               s_valid;
  logic               m_ready;

  logic signed [15:0] a_data;
  logic               a_valid, a_full, a_ovf;
  logic [2:0]         a_level;
  logic signed [11:0] b_data;
  logic               b_valid, b_full, b_ovf;
  logic [2:0]         b_level;
`ifdef FIR4_OUT_SAT_CNT_EN
  logic [15:0]        a_sat, b_sat;
`endif

  fir4_out_stage #(.w(16), .OW(16), .SHIFT(2), .DEPTH(4)) u_a (
    .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_valid(s_valid),
    .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready),
    .level(a_level), .full(a_full), .overflow(a_ovf)
`ifdef FIR4_OUT_SAT_CNT_EN
    , .sat_cnt(a_sat)
`endif
  );

  fir4_out_stage #(.w(16), .OW(12), .SHIFT(2), .DEPTH(4)) u_b (
    .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_valid(s_valid),
    .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready),
    .level(b_level), .full(b_full), .overflow(b_ovf)
`ifdef FIR4_OUT_SAT_CNT_EN
    , .sat_cnt(b_sat)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model for the OW=16 instance ----------------
  int q[$];
  bit p1v = 1'b0, p2v = 1'b0, movf = 1'b0;
  int p1r = 0, p2d = 0;

  // floor((s + 2) / 4) using integer division on magnitudes
  function automatic int rnd4(input int s);
    int t;
    t = s + 2;
    if (t >= 0) return t / 4;
    else return -((-t + 3) / 4);
  endfunction

  function automatic int sat16(input int r);
    if (r > 32767) return 32767;
    else if (r < -32768) return -32768;
    else return r;
  endfunction

  task automatic model_reset();
    q.delete();
    p1v = 1'b0; p2v = 1'b0; movf = 1'b0; p1r = 0; p2d = 0;
  endtask

  // Called at a negedge: drive inputs, advance model across posedge, check at next negedge.
  task automatic step(input int s, input bit v, input bit rdy);
    bit pop;
    s_in = 18'(s); s_valid = v; m_ready = rdy;
    @(posedge clk);
    pop = (q.size() > 0) && rdy;
    if (pop) void'(q.pop_front());
    if (p2v) begin
      if (q.size() < 4) q.push_back(p2d);
      else movf = 1'b1;
    end
    p2v = p1v; p2d = sat16(p1r);
    p1v = v;   p1r = rnd4(s);
    @(negedge clk);
    chk("mdl_valid", a_valid, (q.size() > 0) ? 1 : 0);
    chk("mdl_data",  a_data,  (q.size() > 0) ? q[0] : 0);
    chk("mdl_level", a_level, q.size());
    chk("mdl_full",  a_full,  (q.size() == 4) ? 1 : 0);
    chk("mdl_ovf",   a_ovf,   movf);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_valid"}, a_valid, 0);
    chk({tag, "_a_data"},  a_data,  0);
    chk({tag, "_a_level"}, a_level, 0);
    chk({tag, "_a_full"},  a_full,  0);
    chk({tag, "_a_ovf"},   a_ovf,   0);
    chk({tag, "_b_valid"}, b_valid, 0);
    chk({tag, "_b_data"},  b_data,  0);
    chk({tag, "_b_level"}, b_level, 0);
`ifdef FIR4_OUT_SAT_CNT_EN
    chk({tag, "_a_sat"}, a_sat, 0);
    chk({tag, "_b_sat"}, b_sat, 0);
`endif
  endtask

  // Called at a negedge: assert reset between edges, check, release at next negedge.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 chk_zero(tag);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int s;
    int e16;
    int e12;
  } vec_t;
  vec_t tv[15];

  initial begin
    tv[0]  = '{10, 3, 3};
    tv[1]  = '{-10, -2, -2};
    tv[2]  = '{6, 2, 2};
    tv[3]  = '{0, 0, 0};
    tv[4]  = '{1, 0, 0};
    tv[5]  = '{2, 1, 1};
    tv[6]  = '{-1, 0, 0};
    tv[7]  = '{-3, -1, -1};
    tv[8]  = '{-6, -1, -1};
    tv[9]  = '{131071, 32767, 2047};
    tv[10] = '{-131072, -32768, -2048};
    tv[11] = '{131069, 32767, 2047};
    tv[12] = '{8190, 2048, 2047};
    tv[13] = '{8189, 2047, 2047};
    tv[14] = '{-8195, -2049, -2048};

    reset_n = 1'b0; s_in = '0; s_valid = 1'b0; m_ready = 1'b0;
    #1 chk_zero("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Rounding / saturation table with latency check (m_ready held high).
    for (int i = 0; i < 15; i++) begin
      step(tv[i].s, 1'b1, 1'b1);
      step(0, 1'b0, 1'b1);
      chk("lat2_valid", a_valid, 0);
      step(0, 1'b0, 1'b1);
      chk("lat3_a_valid", a_valid, 1);
      chk("lat3_a_data",  a_data,  tv[i].e16);
      chk("lat3_b_valid", b_valid, 1);
      chk("lat3_b_data",  b_data,  tv[i].e12);
      step(0, 1'b0, 1'b1);
      chk("popped_valid", a_valid, 0);
    end
`ifdef FIR4_OUT_SAT_CNT_EN
    chk("sat_cnt_a", a_sat, 1);
    chk("sat_cnt_b", b_sat, 5);
`endif

    // Async reset mid-stream with samples stored and in flight.
    for (int i = 0; i < 5; i++) step(40, 1'b1, 1'b0);
    chk("pre_rst_level", a_level, 3);
    do_reset("midrst");
    step(20, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("rst_lat2_valid", a_valid, 0);
    step(0, 1'b0, 1'b1);
    chk("rst_lat3_valid", a_valid, 1);
    chk("rst_lat3_data",  a_data,  5);
    step(0, 1'b0, 1'b1);

    // Overflow: six samples into a stalled FIFO, last two dropped.
    do_reset("t4");
    for (int i = 1; i <= 6; i++) step(i, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0);
    chk("t4_level", a_level, 4);
    chk("t4_full",  a_full,  1);
    chk("t4_ovf",   a_ovf,   1);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_drain_data", a_data, (i + 2) / 4);
      step(0, 1'b0, 1'b1);
    end
    chk("t4_empty", a_valid, 0);
    chk("t4_ovf_sticky", a_ovf, 1);

    // Full with simultaneous pop: sample i is 4*i so it rounds to i.
    do_reset("t5");
    for (int n = 1; n <= 20; n++) begin
      step((n <= 14) ? 4 * n : 0, (n <= 14), (n >= 7));
      if (n >= 6 && n <= 16) begin
        chk("t5_level", a_level, 4);
        chk("t5_ovf",   a_ovf,   0);
        chk("t5_data",  a_data,  n - 5);
      end
    end

    // Random back-to-back stream with random stalls.
    do_reset("t6");
    for (int n = 0; n < 100; n++) begin
      step(int'($urandom_range(0, 262143)) - 131072, 1'b1, ($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < 10; n++) step(0, 1'b0, 1'b1);
    chk("t6_drained", a_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
